// File: rtl/xip_line_cache_ctrl.sv
// Direct-mapped read-only line cache in front of the QSPI XIP line reader.
// Hits are served from flop storage; misses fetch one whole line from flash.

module xip_line_cache_line #(
    parameter int TAGW = 16,
    parameter int LW   = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            fill,
    input  logic [TAGW-1:0] fill_tag,
    input  logic [LW-1:0]   fill_data,
    output logic            valid,
    output logic [TAGW-1:0] tag,
    output logic [LW-1:0]   data
);
    // clear beats fill so an invalidate pending across a fill drops the new line
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       valid <= 1'b0;
        else if (clr)  valid <= 1'b0;
        else if (fill) valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag  <= fill_tag;
            data <= fill_data;
        end
    end
endmodule

module xip_line_cache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int LINE_SIZE = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [23:0]            addr,
    input  logic                   rd,
    input  logic                   inv,
    output logic                   ready,
    output logic [31:0]            rdata,
    output logic                   fl_rd,
    output logic [23:0]            fl_addr,
    input  logic                   fl_done,
    input  logic [LINE_SIZE*8-1:0] fl_line,
    output logic [15:0]            hit_cnt,
    output logic [15:0]            miss_cnt
);
    localparam int OFF  = $clog2(LINE_SIZE);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = 24 - OFF - IDX;
    localparam int LW   = LINE_SIZE * 8;
    localparam int WW   = (OFF > 2) ? OFF - 2 : 1;

    typedef enum logic [1:0] {IDLE, CHECK, REQ, WAIT} state_t;

    state_t state, state_nx;
    logic [23:2] req_addr;
    logic        inv_pend;

    logic [NUM_LINES-1:0]           valid;
    logic [NUM_LINES-1:0][TAGW-1:0] tags;
    logic [NUM_LINES-1:0][LW-1:0]   data;

    logic [IDX-1:0]  idx;
    logic [TAGW-1:0] req_tag;
    logic [WW-1:0]   wsel;
    logic            hit, accept, do_hit, do_miss, do_fill, clr_all, inv_now;
    logic            unused_addr;

    assign unused_addr = ^addr[1:0];
    assign idx     = req_addr[OFF+IDX-1:OFF];
    assign req_tag = req_addr[23:OFF+IDX];
    assign hit     = valid[idx] && (tags[idx] == req_tag);

    generate
        if (OFF > 2) begin : g_wsel
            assign wsel = req_addr[OFF-1:2];
        end else begin : g_wsel1
            assign wsel = '0;
        end
    endgenerate

    function automatic logic [31:0] pick(input logic [LW-1:0] line, input logic [WW-1:0] w);
        int unsigned base;
        base = 32 * w;
        return line[base +: 32];
    endfunction

    generate
        for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
            xip_line_cache_line #(.TAGW(TAGW), .LW(LW)) u_line (
                .clk      (clk),
                .rst      (rst),
                .clr      (clr_all),
                .fill     (do_fill && (idx == IDX'(i))),
                .fill_tag (req_tag),
                .fill_data(fl_line),
                .valid    (valid[i]),
                .tag      (tags[i]),
                .data     (data[i])
            );
        end
    endgenerate

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        do_hit   = 1'b0;
        do_miss  = 1'b0;
        do_fill  = 1'b0;
        case (state)
            IDLE:  if (rd) begin accept = 1'b1; state_nx = CHECK; end
            CHECK: if (hit) begin do_hit = 1'b1; state_nx = IDLE; end
                   else begin do_miss = 1'b1; state_nx = REQ; end
            REQ:   state_nx = WAIT;
            WAIT:  if (fl_done) begin do_fill = 1'b1; state_nx = IDLE; end
            default: state_nx = IDLE;
        endcase
        // an invalidate seen while busy is deferred to the edge back into IDLE
        inv_now = inv_pend | inv;
        clr_all = (state == IDLE) ? inv : (state_nx == IDLE) && inv_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req_addr <= '0;
            inv_pend <= 1'b0;
            ready    <= 1'b0;
            rdata    <= '0;
            fl_rd    <= 1'b0;
            fl_addr  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_nx;
            inv_pend <= (state != IDLE) && (state_nx != IDLE) && inv_now;
            if (accept) req_addr <= addr[23:2];
            ready <= do_hit | do_fill;
            fl_rd <= do_miss;
            if (do_hit)  rdata <= pick(data[idx], wsel);
            if (do_fill) rdata <= pick(fl_line, wsel);
            if (do_miss) fl_addr <= {req_addr[23:OFF], {OFF{1'b0}}};
            if (do_hit && hit_cnt != 16'hFFFF)   hit_cnt  <= hit_cnt + 16'd1;
            if (do_miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_xip_line_cache_ctrl.sv
// Bench for xip_line_cache_ctrl: flash line model, ready/rdata scoreboard and
// one task per scenario.

module tb_xip_line_cache_ctrl;
    logic         clk = 1'b0;
    logic         rst, rd, inv, ready, fl_rd, fl_done;
    logic [23:0]  addr, fl_addr;
    logic [31:0]  rdata;
    logic [127:0] fl_line;
    logic [15:0]  hit_cnt, miss_cnt;

    xip_line_cache_ctrl #(.NUM_LINES(16), .LINE_SIZE(16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .inv(inv),
        .ready(ready), .rdata(rdata), .fl_rd(fl_rd), .fl_addr(fl_addr),
        .fl_done(fl_done), .fl_line(fl_line), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0, cyc = 0;
    int fl_n = 0, rdy_n = 0, last_fl_cyc = -1, last_done_cyc = -1, last_rdy_cyc = -1, rd_cyc = 0;
    logic [23:0] last_fl_addr = '0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;
    int fl_lat = 40;
    logic [23:0] fm_la;

    always @(posedge clk) cyc <= cyc + 1;

    // flash content: byte i of line la
    function automatic logic [7:0] fbyte(input logic [23:0] la, input int i);
        return 8'(i) ^ la[23:16] ^ {la[15:12], la[7:4]};
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [23:0] la;
        int w;
        la = {a[23:4], 4'h0};
        w  = int'(a[3:2]);
        return {fbyte(la, 4*w+3), fbyte(la, 4*w+2), fbyte(la, 4*w+1), fbyte(la, 4*w)};
    endfunction

    // flash line reader model
    initial begin fl_done = 1'b0; fl_line = '0; end
    always begin
        @(negedge clk);
        if (fl_rd && !rst) begin
            fm_la = fl_addr;
            repeat (fl_lat) @(posedge clk);
            #1;
            fl_done = 1'b1;
            for (int i = 0; i < 16; i++) fl_line[8*i +: 8] = fbyte(fm_la, i);
            @(posedge clk);
            #1;
            fl_done = 1'b0;
        end
    end

    // monitor + scoreboard
    always @(negedge clk) begin
        if (fl_rd) begin fl_n++; last_fl_cyc = cyc; last_fl_addr = fl_addr; end
        if (fl_done) last_done_cyc = cyc;
        if (ready) begin
            rdy_n++;
            last_rdy_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_ready: got rdata=%h, required no ready", rdata);
            end else begin
                sb_exp = exp_q.pop_front();
                if (rdata !== sb_exp) begin
                    fails++;
                    $display("FAIL sb_rdata: got %h, required %h", rdata, sb_exp);
                end
            end
        end
    end

    task automatic pulse_rd(input logic [23:0] a);
        addr = a; rd = 1'b1; rd_cyc = cyc;
        exp_q.push_back(exp_word(a));
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = ready;
        end
        @(posedge clk); #1;
        if (!got) begin
            checks++; fails++;
            $display("FAIL %s_timeout: got no ready in 200 cycles, required ready", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rd = 1'b0; inv = 1'b0; addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (ready !== 1'b0)     begin fails++; $display("FAIL rst_ready: got %b, required 0", ready); end
        if (rdata !== 32'h0)    begin fails++; $display("FAIL rst_rdata: got %h, required 0", rdata); end
        if (fl_rd !== 1'b0)     begin fails++; $display("FAIL rst_fl_rd: got %b, required 0", fl_rd); end
        if (fl_addr !== 24'h0)  begin fails++; $display("FAIL rst_fl_addr: got %h, required 0", fl_addr); end
        if (hit_cnt !== 16'h0)  begin fails++; $display("FAIL rst_hit_cnt: got %0d, required 0", hit_cnt); end
        if (miss_cnt !== 16'h0) begin fails++; $display("FAIL rst_miss_cnt: got %0d, required 0", miss_cnt); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        int f0, r0;
        f0 = fl_n;
        pulse_rd(24'h000104);
        r0 = rd_cyc;
        wait_ready("cold");
        checks += 7;
        if (last_fl_cyc !== r0 + 2) begin fails++; $display("FAIL cold_fl_rd_cycle: got %0d, required %0d", last_fl_cyc - r0, 2); end
        if (fl_n - f0 !== 1)        begin fails++; $display("FAIL cold_fl_rd_width: got %0d, required 1", fl_n - f0); end
        if (last_fl_addr !== 24'h000100) begin fails++; $display("FAIL cold_fl_addr: got %h, required 000100", last_fl_addr); end
        if (last_rdy_cyc !== last_done_cyc + 1) begin fails++; $display("FAIL cold_latency: got %0d, required 1", last_rdy_cyc - last_done_cyc); end
        if (rdata !== 32'h07060504) begin fails++; $display("FAIL cold_rdata: got %h, required 07060504", rdata); end
        if (miss_cnt !== 16'd1)     begin fails++; $display("FAIL cold_miss_cnt: got %0d, required 1", miss_cnt); end
        if (hit_cnt !== 16'd0)      begin fails++; $display("FAIL cold_hit_cnt: got %0d, required 0", hit_cnt); end
    endtask

    task automatic test_hit();
        int f0, r0;
        f0 = fl_n;
        pulse_rd(24'h00010C);
        r0 = rd_cyc;
        wait_ready("hit");
        checks += 4;
        if (last_rdy_cyc !== r0 + 2) begin fails++; $display("FAIL hit_latency: got %0d, required 2", last_rdy_cyc - r0); end
        if (fl_n !== f0)             begin fails++; $display("FAIL hit_fl_rd: got %0d pulses, required 0", fl_n - f0); end
        if (rdata !== 32'h0F0E0D0C)  begin fails++; $display("FAIL hit_rdata: got %h, required 0F0E0D0C", rdata); end
        if (hit_cnt !== 16'd1)       begin fails++; $display("FAIL hit_cnt: got %0d, required 1", hit_cnt); end
    endtask

    task automatic test_conflict();
        int f0;
        f0 = fl_n;
        pulse_rd(24'h010100);
        wait_ready("conflict_a");
        checks += 2;
        if (fl_n - f0 !== 1) begin fails++; $display("FAIL conflict_a_fl_rd: got %0d, required 1", fl_n - f0); end
        if (last_fl_addr !== 24'h010100) begin fails++; $display("FAIL conflict_a_fl_addr: got %h, required 010100", last_fl_addr); end
        pulse_rd(24'h000100);
        wait_ready("conflict_b");
        checks += 3;
        if (fl_n - f0 !== 2) begin fails++; $display("FAIL conflict_b_fl_rd: got %0d, required 2", fl_n - f0); end
        if (last_fl_addr !== 24'h000100) begin fails++; $display("FAIL conflict_b_fl_addr: got %h, required 000100", last_fl_addr); end
        if (miss_cnt !== 16'd3) begin fails++; $display("FAIL conflict_miss_cnt: got %0d, required 3", miss_cnt); end
    endtask

    task automatic test_back_to_back();
        int r0, n0;
        n0 = rdy_n;
        pulse_rd(24'h000108);
        r0 = rd_cyc;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1) begin fails++; $display("FAIL b2b_first_ready: got %b, required 1", ready); end
        pulse_rd(24'h000100);
        wait_ready("b2b");
        checks += 3;
        if (last_rdy_cyc !== r0 + 4) begin fails++; $display("FAIL b2b_latency: got %0d, required 4", last_rdy_cyc - r0); end
        if (rdy_n - n0 !== 2)        begin fails++; $display("FAIL b2b_ready_count: got %0d, required 2", rdy_n - n0); end
        if (hit_cnt !== 16'd3)       begin fails++; $display("FAIL b2b_hit_cnt: got %0d, required 3", hit_cnt); end
    endtask

    task automatic test_invalidate();
        int f0;
        f0 = fl_n;
        inv = 1'b1;
        @(posedge clk); #1;
        inv = 1'b0;
        pulse_rd(24'h000100);
        wait_ready("inv_idle");
        checks++;
        if (fl_n - f0 !== 1) begin fails++; $display("FAIL inv_idle_miss: got %0d fl_rd, required 1", fl_n - f0); end
        inv = 1'b1;
        pulse_rd(24'h000104);
        inv = 1'b0;
        wait_ready("inv_with_rd");
        checks++;
        if (fl_n - f0 !== 2) begin fails++; $display("FAIL inv_with_rd_miss: got %0d fl_rd, required 2", fl_n - f0); end
        pulse_rd(24'h002000);
        repeat (10) @(posedge clk);
        #1;
        inv = 1'b1;
        @(posedge clk); #1;
        inv = 1'b0;
        wait_ready("inv_wait");
        pulse_rd(24'h002000);
        wait_ready("inv_wait_reread");
        checks += 2;
        if (fl_n - f0 !== 4)    begin fails++; $display("FAIL inv_wait_reread_miss: got %0d fl_rd, required 4", fl_n - f0); end
        if (miss_cnt !== 16'd7) begin fails++; $display("FAIL inv_miss_cnt: got %0d, required 7", miss_cnt); end
    endtask

    task automatic test_busy_rd();
        int f0, n0, r0;
        f0 = fl_n; n0 = rdy_n;
        pulse_rd(24'h003000);
        repeat (10) @(posedge clk);
        #1;
        addr = 24'h00010C; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        wait_ready("busy");
        repeat (5) @(posedge clk);
        #1;
        checks += 2;
        if (fl_n - f0 !== 1)  begin fails++; $display("FAIL busy_fl_rd: got %0d, required 1", fl_n - f0); end
        if (rdy_n - n0 !== 1) begin fails++; $display("FAIL busy_ready: got %0d, required 1", rdy_n - n0); end
        pulse_rd(24'h003004);
        r0 = rd_cyc;
        wait_ready("busy_next");
        checks += 3;
        if (last_rdy_cyc !== r0 + 2) begin fails++; $display("FAIL busy_next_latency: got %0d, required 2", last_rdy_cyc - r0); end
        if (fl_n - f0 !== 1)    begin fails++; $display("FAIL busy_next_fl_rd: got %0d, required 1", fl_n - f0); end
        if (hit_cnt !== 16'd4)  begin fails++; $display("FAIL busy_hit_cnt: got %0d, required 4", hit_cnt); end
    endtask

    task automatic test_reset_mid_fill();
        int f0, n0;
        pulse_rd(24'h004000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks += 4;
        if (ready !== 1'b0)     begin fails++; $display("FAIL rstmid_ready: got %b, required 0", ready); end
        if (fl_rd !== 1'b0)     begin fails++; $display("FAIL rstmid_fl_rd: got %b, required 0", fl_rd); end
        if (hit_cnt !== 16'h0)  begin fails++; $display("FAIL rstmid_hit_cnt: got %0d, required 0", hit_cnt); end
        if (miss_cnt !== 16'h0) begin fails++; $display("FAIL rstmid_miss_cnt: got %0d, required 0", miss_cnt); end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        n0 = rdy_n;
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (rdy_n !== n0) begin fails++; $display("FAIL rstmid_late_done: got %0d ready, required 0", rdy_n - n0); end
        f0 = fl_n;
        pulse_rd(24'h004000);
        wait_ready("rstmid_reread");
        checks += 2;
        if (fl_n - f0 !== 1)    begin fails++; $display("FAIL rstmid_reread_miss: got %0d fl_rd, required 1", fl_n - f0); end
        if (miss_cnt !== 16'd1) begin fails++; $display("FAIL rstmid_reread_miss_cnt: got %0d, required 1", miss_cnt); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_back_to_back();
        test_invalidate();
        test_busy_rd();
        test_reset_mid_fill();
        checks++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/xip_line_cache_ctrl.md
Name: xip_line_cache_ctrl

Overview:
- Direct-mapped read-only line cache and sequencer in front of the QSPI XIP flash line reader.
- Serves 32-bit word reads from the CPU/bus side. A hit returns data from local line storage. A miss issues one line-read request to the flash controller and fills the line when the reader reports done.
- Sits between the bus adapter and the XIP flash controller, and is the only source of that controller's rd pulses.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, ≥2.
- LINE_SIZE, 16, bytes per line; power of two, ≥4. Must match the flash controller's LINE_SIZE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- addr  in  24  byte address of requested word; sampled only when rd is accepted
- rd  in  1  single-cycle read request
- inv  in  1  single-cycle invalidate-all request
- ready  out  1  one-cycle pulse; rdata valid in that cycle
- rdata  out  32  requested word, held until the next ready
- fl_rd  out  1  one-cycle line-read request to the flash controller
- fl_addr  out  24  line-aligned flash address, held stable from fl_rd until fl_done
- fl_done  in  1  one-cycle pulse; fl_line valid
- fl_line  in  LINE_SIZE*8  line data; byte i at bits [8i+7:8i]
- hit_cnt  out  16  saturating hit counter
- miss_cnt  out  16  saturating miss counter

Behaviour:
- Interface: one clock clk; rst is asynchronous and active-high.
- Address split:
  - OFF = log2(LINE_SIZE), IDX = log2(NUM_LINES).
  - Index = addr[OFF+IDX-1:OFF]; tag = addr[23:OFF+IDX].
  - Word select = addr[OFF-1:2]; addr[1:0] ignored.
  - Word w = bytes 4w..4w+3, little-endian (byte 4w in rdata[7:0]).
- Storage:
  - Per line: valid bit, tag, LINE_SIZE*8 data bits, all in flops.
  - Data and tags have no reset; valid bits do.
- Reset values: state IDLE, all valid=0, ready=0, rdata=0, fl_rd=0, fl_addr=0, hit_cnt=0, miss_cnt=0, inv_pend=0. Reset takes effect immediately, including mid-fill.
- FSM states: IDLE, CHECK, REQ, WAIT.
  - IDLE: rd=1 latches addr into req_addr; next state CHECK. rd is accepted only in IDLE; rd in any other state is ignored, with no queueing.
  - CHECK: hit when valid[idx] and the stored tag equals req_tag.
    - Hit: ready<=1, rdata<=selected word, hit_cnt++, next state IDLE.
    - Miss: fl_addr<={req_addr[23:OFF],OFF'b0}, fl_rd<=1, miss_cnt++, next state REQ.
  - REQ: fl_rd<=0, next state WAIT. fl_rd is therefore high for exactly one cycle.
  - WAIT: on fl_done, the line at idx takes fl_line, the tag takes req_tag, valid=1; ready<=1; rdata<=word from fl_line (bypass, not re-read); next state IDLE. The controller waits indefinitely; there is no timeout.
- fl_done outside WAIT is ignored.
- Latency:
  - Hit: rd in cycle 0, ready in cycle 2.
  - Miss: fl_rd in cycle 2; ready in the cycle after fl_done.
- Back-to-back: rd may be asserted in the same cycle as ready. The FSM is then in IDLE, so the request is accepted.
- Invalidate:
  - inv in IDLE: all valid bits clear at the next edge.
  - inv with rd in IDLE: both take effect; the request is evaluated against the cleared valid bits and misses.
  - inv in CHECK/REQ/WAIT: sets inv_pend. On the edge returning to IDLE, all valid bits clear, including a line just filled; the in-flight ready/rdata is still delivered. inv_pend then clears.
- Counters: increment by 1 per hit or miss; saturate at 16'hFFFF; cleared only by rst.
- Line replacement: direct-mapped, unconditional overwrite on fill.

Test Plan:
- Cold miss:
  - After rst, rd addr=24'h000104 → fl_rd one cycle in cycle 2 with fl_addr=24'h000100.
  - Model returns bytes 8'h00..8'h0F after 40 cycles → ready the cycle after fl_done, rdata=32'h07060504, miss_cnt=1.
- Hit: then rd addr=24'h00010C → ready exactly 2 cycles after rd, rdata=32'h0F0E0D0C, no fl_rd, hit_cnt=1.
- Conflict:
  - rd 24'h010100 (same index 0, tag 16'h0101) → miss, fl_addr=24'h010100, line replaced.
  - rd 24'h000100 → miss again; miss_cnt=3.
- Invalidate during fill: pulse inv while in WAIT → ready/rdata delivered normally; subsequent rd of the same address misses (fl_rd asserted).
- Busy rd: extra rd pulse during WAIT → ignored; exactly one ready, one fl_rd; the next rd after ready is accepted.
- Reset mid-fill: rst in WAIT → ready=0, fl_rd=0, counters 0; a late fl_done produces no ready, and the following rd misses.
